bdc_pwm_gen: RTL and testbench

Parametrised multi-channel H-bridge PWM generator for the brushed-DC motor driver, replacing the fixed-prescale single-output toggler. It holds one shared period counter and drives N_CH complementary output pairs (out1/out2 per bridge) with per-channel duty, direction and dead-time on direction reversal. All configuration is double-buffered and takes effect only at a period boundary, so duty and direction changes never produce runt pulses.

---
 rtl/bdc_pwm_gen.sv | 171 +++++++++++++++++
 tb/tb_bdc_pwm_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bdc_pwm_gen.sv
// Multi-channel H-bridge PWM generator: one shared period counter, per-channel
// duty/direction with double-buffered configuration and reversal dead-time.
module bdc_pwm_gen #(
    parameter int unsigned      N_CH       = 2,
    parameter int unsigned      CNT_W      = 20,
    parameter int unsigned      DEAD_CYC   = 16,
    parameter logic [CNT_W-1:0] DEF_PERIOD = 20'd491519,
    localparam int unsigned     CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              period_wr,
    input  logic [CNT_W-1:0]  period_in,
    input  logic              duty_wr,
    input  logic [CH_W-1:0]   duty_ch,
    input  logic [CNT_W:0]    duty_in,
    input  logic              dir_in,
    output logic [N_CH-1:0]   out1,
    output logic [N_CH-1:0]   out2,
    output logic              tick,
    output logic [N_CH:0]     pend
);

    localparam int unsigned DT_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD_CYC);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic [CNT_W-1:0] period_pend_reg, period_pend_next;
    logic             per_pend_reg, per_pend_next;
    logic             tick_reg, tick_next;
    logic             wrap;
    logic [N_CH-1:0]  ch_pend;

    assign wrap = en && (cnt_reg == period_reg);

    always_comb begin
        cnt_next         = '0;
        period_next      = period_reg;
        period_pend_next = period_pend_reg;
        per_pend_next    = per_pend_reg;
        if (en && !wrap) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
        if (period_wr) begin
            period_pend_next = period_in;
        end
        if (!en) begin
            // Stopped: writes (or anything left pending) go straight to active.
            per_pend_next = 1'b0;
            if (period_wr) begin
                period_next = period_in;
            end else if (per_pend_reg) begin
                period_next = period_pend_reg;
            end
        end else begin
            if (wrap && per_pend_reg) begin
                period_next = period_pend_reg;
            end
            if (period_wr) begin
                per_pend_next = 1'b1;
            end else if (wrap) begin
                per_pend_next = 1'b0;
            end
        end
        // Registered tick lands in the cycle where the counter sits at terminal count.
        tick_next = en && (cnt_next == period_next);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg         <= '0;
            period_reg      <= DEF_PERIOD;
            period_pend_reg <= DEF_PERIOD;
            per_pend_reg    <= 1'b0;
            tick_reg        <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            period_reg      <= period_next;
            period_pend_reg <= period_pend_next;
            per_pend_reg    <= per_pend_next;
            tick_reg        <= tick_next;
        end
    end

    assign tick = tick_reg;
    assign pend = {per_pend_reg, ch_pend};

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W:0]  duty_reg, duty_next;
            logic [CNT_W:0]  duty_pend_reg, duty_pend_next;
            logic            dir_reg, dir_next;
            logic            dir_pend_reg, dir_pend_next;
            logic            pend_reg, pend_next;
            logic [DT_W-1:0] dt_reg, dt_next;
            logic            out1_reg, out1_next;
            logic            out2_reg, out2_next;
            logic            wr_hit;
            logic            pwm;

            assign wr_hit = duty_wr && (duty_ch == CH_W'(gi));
            assign pwm    = ({1'b0, cnt_reg} < duty_reg);

            always_comb begin
                duty_next      = duty_reg;
                dir_next       = dir_reg;
                pend_next      = pend_reg;
                dt_next        = '0;
                duty_pend_next = wr_hit ? duty_in : duty_pend_reg;
                dir_pend_next  = wr_hit ? dir_in : dir_pend_reg;
                if (!en) begin
                    pend_next = 1'b0;
                    if (wr_hit) begin
                        duty_next = duty_in;
                        dir_next  = dir_in;
                    end else if (pend_reg) begin
                        duty_next = duty_pend_reg;
                        dir_next  = dir_pend_reg;
                    end
                end else begin
                    if (dt_reg != '0) begin
                        dt_next = dt_reg - DT_W'(1);
                    end
                    if (wrap && pend_reg) begin
                        duty_next = duty_pend_reg;
                        dir_next  = dir_pend_reg;
                        if (dir_pend_reg != dir_reg) begin
                            dt_next = DT_LOAD;
                        end
                    end
                    if (wr_hit) begin
                        pend_next = 1'b1;
                    end else if (wrap) begin
                        pend_next = 1'b0;
                    end
                end
                out1_next = en && (dt_reg == '0) && !dir_reg && pwm;
                out2_next = en && (dt_reg == '0) &&  dir_reg && pwm;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    duty_reg      <= '0;
                    duty_pend_reg <= '0;
                    dir_reg       <= 1'b0;
                    dir_pend_reg  <= 1'b0;
                    pend_reg      <= 1'b0;
                    dt_reg        <= '0;
                    out1_reg      <= 1'b0;
                    out2_reg      <= 1'b0;
                end else begin
                    duty_reg      <= duty_next;
                    duty_pend_reg <= duty_pend_next;
                    dir_reg       <= dir_next;
                    dir_pend_reg  <= dir_pend_next;
                    pend_reg      <= pend_next;
                    dt_reg        <= dt_next;
                    out1_reg      <= out1_next;
                    out2_reg      <= out2_next;
                end
            end

            assign out1[gi]    = out1_reg;
            assign out2[gi]    = out2_reg;
            assign ch_pend[gi] = pend_reg;
        end
    endgenerate

endmodule

// File: tb/tb_bdc_pwm_gen.sv
// Scoreboard bench for bdc_pwm_gen: expectations queued per clock as stimulus
// is driven, checked half a clock later against {out1,out2,tick,pend}.
module tb_bdc_pwm_gen;

    localparam int N_CH  = 3;
    localparam int CNT_W = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              period_wr;
    logic [CNT_W-1:0]  period_in;
    logic              duty_wr;
    logic [1:0]        duty_ch;
    logic [CNT_W:0]    duty_in;
    logic              dir_in;
    logic [N_CH-1:0]   out1;
    logic [N_CH-1:0]   out2;
    logic              tick;
    logic [N_CH:0]     pend;

    int n_vec = 0;
    int n_err = 0;

    logic [10:0] exp_q [$];
    string       tag_q [$];

    bdc_pwm_gen #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .DEAD_CYC  (4),
        .DEF_PERIOD(20'd29)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .period_wr(period_wr),
        .period_in(period_in),
        .duty_wr  (duty_wr),
        .duty_ch  (duty_ch),
        .duty_in  (duty_in),
        .dir_in   (dir_in),
        .out1     (out1),
        .out2     (out2),
        .tick     (tick),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got o1/o2/tick/pend=%b_%b_%b_%b want %b_%b_%b_%b", tag,
                     got[10:8], got[7:5], got[4], got[3:0], exp[10:8], exp[7:5], exp[4], exp[3:0]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [10:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {out1, out2, tick, pend}, e);
        end
    end

    task automatic cyc(input logic [10:0] e, input string tag);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // One period (or its first n counts) with a fixed active configuration.
    // Expected level for count c is c < duty; ch0 is blanked while c < dt0.
    // An optional single write is strobed in the cycle whose count is wr_c.
    task automatic run_period(input int p, input int n, input int d0, input int d1, input int d2,
                              input logic [2:0] dirm, input int dt0, input logic [3:0] pend0,
                              input int wr_c, input logic [3:0] wr_bit, input logic is_per,
                              input int wr_ch, input int wr_val, input logic wr_dir, input string tag);
        for (int c = 0; c < n; c++) begin
            logic [2:0] lvl;
            logic [2:0] o1;
            logic [2:0] o2;
            logic       tk;
            logic [3:0] pm;
            if (c == wr_c) begin
                if (is_per) begin
                    period_wr = 1'b1;
                    period_in = CNT_W'(wr_val);
                end else begin
                    duty_wr = 1'b1;
                    duty_ch = 2'(wr_ch);
                    duty_in = (CNT_W + 1)'(wr_val);
                    dir_in  = wr_dir;
                end
            end
            lvl = {c < d2, c < d1, (c < d0) && (c >= dt0)};
            o1  = lvl & ~dirm;
            o2  = lvl & dirm;
            tk  = (c + 1 == p);
            if (c < p) begin
                pm = pend0 | ((wr_c >= 0 && c >= wr_c) ? wr_bit : 4'b0000);
            end else begin
                pm = (wr_c == p) ? wr_bit : 4'b0000;
            end
            cyc({o1, o2, tk, pm}, $sformatf("%s_c%0d", tag, c));
            period_wr = 1'b0;
            duty_wr   = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b0;
        en        = 1'b0;
        period_wr = 1'b0;
        period_in = '0;
        duty_wr   = 1'b0;
        duty_ch   = '0;
        duty_in   = '0;
        dir_in    = 1'b0;

        cyc(11'd0, "in_reset");
        cyc(11'd0, "in_reset");
        reset = 1'b1;
        cyc(11'd0, "idle");
        cyc(11'd0, "idle");

        // Stopped: writes take effect at once and never show as pending.
        period_wr = 1'b1; period_in = 20'd9;
        cyc(11'd0, "stop_per_wr");
        period_wr = 1'b0;
        duty_wr = 1'b1; duty_ch = 2'd0; duty_in = 21'd3; dir_in = 1'b0;
        cyc(11'd0, "stop_duty_wr");
        duty_ch = 2'd3; duty_in = 21'd7;
        cyc(11'd0, "stop_bad_ch");
        duty_wr = 1'b0;

        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_period(9, 10, 3, 0, 0, 3'b000, 0, 4'b0000, -1, 4'b0000, 1'b0, 0, 0, 1'b0, "d3");
        end
        run_period(9, 10, 3, 0, 0, 3'b000, 0, 4'b0000, 5, 4'b0001, 1'b0, 0, 0, 1'b0, "wr_d0");
        run_period(9, 10, 0, 0, 0, 3'b000, 0, 4'b0000, 9, 4'b0001, 1'b0, 0, 10, 1'b0, "d0_wr_on_tick");
        run_period(9, 10, 0, 0, 0, 3'b000, 0, 4'b0001, -1, 4'b0000, 1'b0, 0, 0, 1'b0, "d0_held");
        run_period(9, 10, 10, 0, 0, 3'b000, 0, 4'b0000, 4, 4'b0010, 1'b0, 1, 5, 1'b0, "full_wr_ch1");
        run_period(9, 10, 10, 5, 0, 3'b000, 0, 4'b0000, 4, 4'b0001, 1'b0, 0, 6, 1'b1, "rev_wr");
        run_period(9, 10, 6, 5, 0, 3'b001, 4, 4'b0000, -1, 4'b0000, 1'b0, 0, 0, 1'b0, "deadtime");
        run_period(9, 10, 6, 5, 0, 3'b001, 0, 4'b0000, 2, 4'b0001, 1'b0, 0, 15, 1'b1, "after_dt");
        run_period(9, 10, 15, 5, 0, 3'b001, 0, 4'b0000, 3, 4'b1000, 1'b1, 0, 14, 1'b0, "per_wr");
        run_period(14, 15, 15, 5, 0, 3'b001, 0, 4'b0000, 1, 4'b0000, 1'b0, 3, 2, 1'b0, "p14_bad_ch");
        run_period(14, 8, 15, 5, 0, 3'b001, 0, 4'b0000, -1, 4'b0000, 1'b0, 0, 0, 1'b0, "pre_rst");

        // Asynchronous reset with out2[0] high mid-period.
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async", {out1, out2, tick, pend}, 11'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_period(29, 30, 0, 0, 0, 3'b000, 0, 4'b0000, -1, 4'b0000, 1'b0, 0, 0, 1'b0, "def_period");

        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
